// File: rtl/gol_pkg.sv
// Shared Game of Life definitions.
// - LOG_BOARD_SIZE: log2 of the board edge length, shared with the sweep FSM.
// - sched_state_t:  generation scheduler states.
package gol_pkg;

    localparam int LOG_BOARD_SIZE = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        SWEEP      = 2'd2,
        SWAP_WAIT  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/frame_rate_div.sv
// Frame counter that paces free-run generations.
// Ports:
//   clk_in    in  system clock
//   rst_in    in  synchronous reset, active-low
//   clear_in  in  force the count back to zero
//   en_in     in  count vsync pulses while high
//   vsync_in  in  one-cycle pulse per display frame
//   rate_in   in  frames per tick; 0 behaves as 1
//   tick_out  out combinational: this vsync completes the programmed frame count
module frame_rate_div #(
    parameter int RATE_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear_in,
    input  logic              en_in,
    input  logic              vsync_in,
    input  logic [RATE_W-1:0] rate_in,
    output logic              tick_out
);

    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [RATE_W:0]   cnt_inc;
    logic [RATE_W:0]   rate_eff;

    // One extra bit so the increment and the compare never overflow.
    assign cnt_inc  = {1'b0, cnt_q} + {{RATE_W{1'b0}}, 1'b1};
    assign rate_eff = (rate_in == '0) ? {{RATE_W{1'b0}}, 1'b1} : {1'b0, rate_in};

    // ">=" rather than "==": a rate lowered below the current count fires on
    // the very next vsync instead of waiting for the counter to wrap.
    assign tick_out = en_in && vsync_in && (cnt_inc >= rate_eff);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_in) begin
            cnt_d = '0;
        end else if (en_in && vsync_in) begin
            // Without a tick cnt_inc < rate_eff, so the MSB is known zero.
            cnt_d = tick_out ? '0 : cnt_inc[RATE_W-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gen_scheduler.sv
// Game of Life generation scheduler.
// Starts the sweep FSM, waits for its done pulse, then swaps the ping-pong
// board buffers on the next vsync so the display never shows a half-updated
// board. Supports free-run (rate_in frames per generation), single-step and
// pause.
// Ports:
//   clk_in / rst_in   clock, synchronous active-low reset
//   run_in            level: 1 free-run, 0 pause
//   step_in           pulse: one generation, honoured only in IDLE
//   rate_in           frames per generation (0 behaves as 1)
//   vsync_in          pulse per display frame
//   sweep_done_in     pulse from the sweep FSM: board update complete
//   sweep_start_out   pulse to the sweep FSM, first SWEEP cycle
//   buf_sel_out       buffer read by display and sweep; sweep writes the other
//   gen_count_out     generations completed (wraps)
//   gen_done_out      pulse on the cycle the buffers swap
//   busy_out          1 whenever the scheduler is not IDLE
//   state_dbg_out     current scheduler state, for observation
// Handshake: start/done are single-cycle pulses with no ready; a done pulse
// outside SWEEP and a step pulse outside IDLE are discarded, never queued.
module gen_scheduler
    import gol_pkg::*;
#(
    parameter int GEN_CNT_W = 16,
    parameter int RATE_W    = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 run_in,
    input  logic                 step_in,
    input  logic [RATE_W-1:0]    rate_in,
    input  logic                 vsync_in,
    input  logic                 sweep_done_in,
    output logic                 sweep_start_out,
    output logic                 buf_sel_out,
    output logic [GEN_CNT_W-1:0] gen_count_out,
    output logic                 gen_done_out,
    output logic                 busy_out,
    output sched_state_t         state_dbg_out
);

    sched_state_t         state_q, state_d;
    logic                 sweep_start_q, sweep_start_d;
    logic                 buf_sel_q, buf_sel_d;
    logic [GEN_CNT_W-1:0] gen_count_q, gen_count_d;
    logic                 gen_done_q, gen_done_d;
    logic                 busy_q, busy_d;

    logic div_clear;
    logic frame_tick;

    // The frame count only lives while free-running in WAIT_FRAME; pausing
    // clears it and the vsync of that same cycle is not counted.
    assign div_clear = (state_q != WAIT_FRAME) || !run_in;

    frame_rate_div #(
        .RATE_W (RATE_W)
    ) u_frame_rate_div (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (div_clear),
        .en_in    (!div_clear),
        .vsync_in (vsync_in),
        .rate_in  (rate_in),
        .tick_out (frame_tick)
    );

    always_comb begin
        state_d       = state_q;
        sweep_start_d = 1'b0;
        buf_sel_d     = buf_sel_q;
        gen_count_d   = gen_count_q;
        gen_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_in) begin
                    state_d = WAIT_FRAME;
                end else if (step_in) begin
                    state_d       = SWEEP;
                    sweep_start_d = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (!run_in) begin
                    state_d = IDLE;
                end else if (frame_tick) begin
                    state_d       = SWEEP;
                    sweep_start_d = 1'b1;
                end
            end
            SWEEP: begin
                // A started sweep always completes; only done matters here.
                if (sweep_done_in) begin
                    state_d = SWAP_WAIT;
                end
            end
            SWAP_WAIT: begin
                if (vsync_in) begin
                    buf_sel_d   = !buf_sel_q;
                    gen_count_d = gen_count_q + 1'b1;
                    gen_done_d  = 1'b1;
                    state_d     = run_in ? WAIT_FRAME : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered from the next state so busy_out lines up with state_q.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            sweep_start_q <= 1'b0;
            buf_sel_q     <= 1'b0;
            gen_count_q   <= '0;
            gen_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_start_q <= sweep_start_d;
            buf_sel_q     <= buf_sel_d;
            gen_count_q   <= gen_count_d;
            gen_done_q    <= gen_done_d;
            busy_q        <= busy_d;
        end
    end

    assign sweep_start_out = sweep_start_q;
    assign buf_sel_out     = buf_sel_q;
    assign gen_count_out   = gen_count_q;
    assign gen_done_out    = gen_done_q;
    assign busy_out        = busy_q;
    assign state_dbg_out   = state_q;

endmodule
